// File: rtl/clk_countdown.sv
// ============================================================================
// Module      : clk_countdown
// Description : Loadable down-counting timer, decremented once every
//               CLOCK_DELAY clk cycles; pulses done on reaching zero.
//               Optional macro CLK_COUNTDOWN_AUTO_RELOAD_EN makes it periodic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_countdown #(
  parameter int COUNT_WIDTH = 4,
  parameter int CLOCK_DELAY = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done
);

  localparam int c_pre_width = (CLOCK_DELAY > 1) ? $clog2(CLOCK_DELAY) : 1;
  localparam logic [c_pre_width-1:0] c_tick_val = c_pre_width'(CLOCK_DELAY - 1);
  localparam logic [COUNT_WIDTH-1:0] c_one      = COUNT_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [c_pre_width-1:0] r_pre;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_tick;

`ifdef CLK_COUNTDOWN_AUTO_RELOAD_EN
  logic [COUNT_WIDTH-1:0] r_reload;
`endif

  assign w_tick = (r_pre == c_tick_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_pre    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef CLK_COUNTDOWN_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (load_value != '0) begin
              r_state  <= S_RUN;
              r_count  <= load_value;
              r_pre    <= '0;
              r_busy   <= 1'b1;
`ifdef CLK_COUNTDOWN_AUTO_RELOAD_EN
              r_reload <= load_value;
`endif
            end else begin
              // Zero load expires immediately without entering RUN.
              r_count <= '0;
              r_done  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (abort) begin
            // Abort beats a coincident final tick: no done pulse.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_pre   <= '0;
          end else if (w_tick) begin
            r_pre <= '0;
            if (r_count == c_one) begin
              r_done  <= 1'b1;
`ifdef CLK_COUNTDOWN_AUTO_RELOAD_EN
              r_count <= r_reload;
`else
              r_count <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
`endif
            end else begin
              r_count <= r_count - c_one;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_count <= '0;
          r_pre   <= '0;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_clk_countdown.sv
// ============================================================================
// Module      : tb_clk_countdown
// Description : Scoreboard bench for clk_countdown (COUNT_WIDTH=4, CLOCK_DELAY=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_countdown;

  localparam int c_cw = 4;
  localparam int c_cd = 4;
`ifdef CLK_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit c_reload = 1'b1;
`else
  localparam bit c_reload = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [c_cw-1:0] load_value;
  logic [c_cw-1:0] count;
  logic            busy;
  logic            done;

  int n_tests;
  int n_fail;
  int cyc;

  typedef struct {
    int cyc;
    int cnt;
    int bsy;
  } exp_t;

  exp_t exp_q[$];

  clk_countdown #(
    .COUNT_WIDTH(c_cw),
    .CLOCK_DELAY(c_cd)
  ) u_dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .abort     (abort),
    .load_value(load_value),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected done pulse: accept edge + n*delay, count/busy per build mode.
  task automatic push_done(input int at, input int cnt, input int bsy);
    exp_t e;
    e.cyc = at;
    e.cnt = cnt;
    e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_count", int'(count), e.cnt);
        check("done_busy", int'(busy), e.bsy);
      end
    end
  end

  task automatic do_start(input int v, output int e0);
    @(negedge clk);
    start      = 1'b1;
    load_value = c_cw'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic abort_pulse();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(count), 0);
  endtask

  // One-shot run of v: expiry at e0 + v*delay.
  task automatic run_expire(input int v, input int e0);
    push_done(e0 + v * c_cd, c_reload ? v : 0, c_reload ? 1 : 0);
    wait_drain(100);
    abort_pulse();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    load_value = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // load 5: count steps every 4 cycles, done 20 cycles after accept
    do_start(5, e0);
    push_done(e0 + 20, c_reload ? 5 : 0, c_reload ? 1 : 0);
    check("l5_count0", int'(count), 5);
    check("l5_busy0", int'(busy), 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(posedge clk);
      #1;
      check("l5_step", int'(count), 5 - k);
    end
    check("l5_busy_late", int'(busy), 1);
    wait_drain(100);
    abort_pulse();

    // load 0: immediate done, stays idle
    do_start(0, e0);
    push_done(e0, 0, 0);
    check("l0_busy", int'(busy), 0);
    check("l0_count", int'(count), 0);
    wait_drain(10);
    @(posedge clk);
    #1;
    check("l0_busy_after", int'(busy), 0);

    // load 3, abort at cycle 6, no done afterwards
    do_start(3, e0);
    repeat (4) @(posedge clk);
    #1;
    check("ab_count_pre", int'(count), 2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_count", int'(count), 0);
    check("ab_busy", int'(busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("ab_no_done", exp_q.size(), 0);

    // start and abort together in IDLE: ignored
    @(negedge clk);
    start      = 1'b1;
    abort      = 1'b1;
    load_value = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", int'(busy), 0);
    check("sa_count", int'(count), 0);
    check("sa_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    check("sa_busy_later", int'(busy), 0);

    // asynchronous reset mid-run
    do_start(3, e0);
    repeat (5) @(posedge clk);
    #1;
    check("ar_count_pre", int'(count), 2);
    #10;
    rst_n = 1'b0;
    #1;
    check("ar_count", int'(count), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1, e0);
    run_expire(1, e0);

    // maximum load value
    do_start(15, e0);
    check("max_count0", int'(count), 15);
    run_expire(15, e0);

    // start during RUN ignored; periodic expiry when reload enabled
    do_start(2, e0);
    @(negedge clk);
    start      = 1'b1;
    load_value = 4'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_count", int'(count), 2);
    check("ign_busy", int'(busy), 1);
    for (int k = 1; k <= (c_reload ? 4 : 1); k++)
      push_done(e0 + 8 * k, c_reload ? 2 : 0, c_reload ? 1 : 0);
    wait_drain(100);
    abort_pulse();
    repeat (12) @(posedge clk);
    #1;
    check("end_queue", exp_q.size(), 0);
    check("end_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_countdown.md
Name: clk_countdown

Overview:
- Loadable down-counting timer driven by a prescaled clock tick; the other direction of the free-running up-counter block.
- Controller loads a start value; block decrements once per CLOCK_DELAY clk cycles and pulses done on reaching zero.
- Used for timeouts and delays in the same 12 MHz clock domain.

Parameters:
COUNT_WIDTH, 4, width of load_value and count.
CLOCK_DELAY, 10, clk cycles per decrement. Must be >= 1. Prescaler width is max(1, $clog2(CLOCK_DELAY)).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  load and begin countdown. Sampled only in IDLE.
abort  input  1  cancel countdown. Takes priority over start.
load_value  input  COUNT_WIDTH  start value, latched on an accepted start.
count  output  COUNT_WIDTH  current remaining count.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, count=0, prescaler=0, busy=0, done=0. A reset mid-RUN aborts the countdown immediately with no done pulse.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE, start=1, abort=0, load_value!=0: next edge goes to RUN, count<=load_value, prescaler<=0, busy<=1.
- IDLE, start=1, abort=0, load_value==0: stay in IDLE, count<=0, done<=1 for exactly one cycle (edge after start).
- IDLE, abort=1: start is ignored and no state change occurs.
- RUN tick: a tick occurs when prescaler==CLOCK_DELAY-1. On a tick, prescaler<=0 and count<=count-1; otherwise prescaler increments.
- With CLOCK_DELAY=1, every RUN cycle is a tick.
- RUN, tick with count==1: count<=0, done<=1, busy<=0, state<=IDLE, all on the same edge.
- Latency: done rises at edge E0 + N*CLOCK_DELAY, where E0 is the start-accept edge and N=load_value. done and count==0 are coincident.
- RUN, abort=1: next edge state<=IDLE, busy<=0, count<=0, prescaler<=0, no done pulse. abort on the same cycle as the final tick also wins, so no done.
- start during RUN is ignored; load_value is not re-sampled.
- done is 0 in every cycle other than the expiry cycle.
- Back-to-back: start may be asserted in the cycle done is high, since state is IDLE. It is accepted on the next edge.
- Arithmetic is unsigned. count never wraps below 0.
- Max load_value is 2^COUNT_WIDTH-1.

Optional Feature:
CLK_COUNTDOWN_AUTO_RELOAD_EN
- Defined: load_value is stored in a reload register on accept.
  - On expiry, done pulses, count<=reload value, prescaler<=0, and state stays RUN with busy=1.
  - Periodic done every N*CLOCK_DELAY cycles until abort or reset.
  - A zero load_value behaves as when undefined: single done, stays IDLE.
- Undefined: one-shot behaviour as above. No reload register is synthesised.

Test Plan:
COUNT_WIDTH=4, CLOCK_DELAY=4, 12 MHz clk.
- Reset then start with load_value=5 -> busy=1 for 20 cycles; count steps 5,4,3,2,1,0 every 4 cycles; done high exactly 1 cycle, 20 cycles after the accept edge, with count=0 and busy=0.
- start with load_value=0 -> done pulses one cycle after start; busy stays 0; count=0.
- load_value=3, abort at cycle 6 -> count=0 and busy=0 on the next edge; no done pulse for 20 further cycles.
- start and abort together in IDLE -> no state change, busy=0, done=0.
- rst driven low mid-RUN (count=2), asynchronously between edges -> count=0, busy=0 and done=0 immediately. After release, a new start with 1 gives done 4 cycles later.
- Second start with load_value=15 during RUN ignored. With CLK_COUNTDOWN_AUTO_RELOAD_EN and load_value=2 -> done every 8 cycles for 4 periods, busy held 1, until abort.
